// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
//   state_e : FSM encoding (RUN, DRAIN, HALTED)
//   slot_t  : one scoreboard entry {valid, rd}
//   slot_hit: true when a valid slot targets the given register
package pipe_ctrl_pkg;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned DRAIN_W      = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } slot_t;

  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Two-entry in-flight destination scoreboard (EXE and MEM slots) with the
// RAW compare against the ID stage sources.
//   clk, rst_n       : clock, async active-low reset
//   adv_i            : pipe advances (mem takes ex); otherwise both slots hold
//   issue_i          : on advance, ex takes the ID instruction instead of empty
//   id_*_i           : ID stage register fields
//   raw_c_o          : combinational RAW hazard against either slot
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             issue_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_writes_i,
  output logic             raw_c_o
);

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  logic  rs_hit, rt_hit;

  // r0 is hard-wired, so a zero source never depends on anything.
  always_comb begin
    rs_hit  = id_uses_rs_i && (id_rs_i != '0) &&
              (slot_hit(ex_q, id_rs_i) || slot_hit(mem_q, id_rs_i));
    rt_hit  = id_uses_rt_i && (id_rt_i != '0) &&
              (slot_hit(ex_q, id_rt_i) || slot_hit(mem_q, id_rt_i));
    raw_c_o = id_valid_i && (rs_hit || rt_hit);
  end

  // Slot update: hold, shift in an empty entry, or shift in the ID instruction.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (adv_i) begin
      mem_d = ex_q;
      ex_d  = '0;
      if (issue_i) begin
        ex_d.valid = id_valid_i && id_writes_i && (id_rd_i != '0);
        ex_d.rd    = id_rd_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall, flush and bubble decisions around EXE,
// HALT drain sequencing and hazard performance counters.
//   inputs : ID instruction fields, ex_branch_taken, mem_busy
//   stall_if/id/exe/mem : hold the corresponding stage
//   flush_if/id         : replace stage contents with NOP
//   bubble_exe          : EXE receives NOP instead of the ID instruction
//   halted              : core stopped (only reset leaves it)
//   cnt_raw, cnt_flush  : RAW stall cycles, taken branch flushes
// Stall/flush/bubble outputs are combinational and valid in the same cycle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_writes,
  input  logic             id_is_halt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_exe,
  output logic             stall_mem,
  output logic             flush_if,
  output logic             flush_id,
  output logic             bubble_exe,
  output logic             halted,
  output logic [WIDTH-1:0] cnt_raw,
  output logic [WIDTH-1:0] cnt_flush
);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [WIDTH-1:0]   cnt_raw_q, cnt_raw_d;
  logic [WIDTH-1:0]   cnt_flush_q, cnt_flush_d;
  logic               raw;
  logic               sb_adv;
  logic               sb_issue;
  logic               br;

  pipe_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .adv_i        (sb_adv),
    .issue_i      (sb_issue),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rs_i (id_uses_rs),
    .id_uses_rt_i (id_uses_rt),
    .id_rd_i      (id_rd),
    .id_writes_i  (id_writes),
    .raw_c_o      (raw)
  );

  // Priority: mem_busy, branch flush, RAW, halt issue.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cnt_raw_d   = cnt_raw_q;
    cnt_flush_d = cnt_flush_q;
    sb_adv      = 1'b0;
    sb_issue    = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_exe   = 1'b0;
    stall_mem   = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    bubble_exe  = 1'b0;
    // A branch seen while in reset must not produce a flush.
    br          = ex_branch_taken && rst_n;

    if (mem_busy) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_exe = 1'b1;
      stall_mem = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (br) begin
            flush_if    = 1'b1;
            flush_id    = 1'b1;
            bubble_exe  = 1'b1;
            sb_adv      = 1'b1;
            cnt_flush_d = cnt_flush_q + WIDTH'(1);
          end else if (raw) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            bubble_exe = 1'b1;
            sb_adv     = 1'b1;
            cnt_raw_d  = cnt_raw_q + WIDTH'(1);
          end else begin
            sb_adv   = 1'b1;
            sb_issue = 1'b1;
            if (id_valid && id_is_halt) begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          sb_adv = 1'b1;
          if (br) begin
            // HALT was on the wrong path: resume normal issue.
            flush_if    = 1'b1;
            flush_id    = 1'b1;
            bubble_exe  = 1'b1;
            cnt_flush_d = cnt_flush_q + WIDTH'(1);
            state_d     = ST_RUN;
            drain_d     = '0;
          end else begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            bubble_exe = 1'b1;
            drain_d    = drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) begin
              state_d = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_exe = 1'b1;
          stall_mem = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          drain_d = '0;
        end
      endcase
    end

    halted = (state_q == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      cnt_raw_q   <= '0;
      cnt_flush_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_raw_q   <= cnt_raw_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign cnt_raw   = cnt_raw_q;
  assign cnt_flush = cnt_flush_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core (IF, ID, EXE, MEM, WB). It owns every stall, flush and bubble decision around the EXE stage. It tracks in-flight destination registers in a two-entry scoreboard (EXE and MEM slots) to detect RAW hazards, reacts to taken branches reported by EXE, and freezes the pipe while data memory is busy. It also sequences the HALT drain and keeps two hazard performance counters.

## Interface
- `WIDTH`, default `` `WIDTH`` (32): counter width.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous reset, active low.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs`, `id_rt` input 5 each: ID source register numbers.
- `id_uses_rs`, `id_uses_rt` input 1 each: the corresponding source is actually read.
- `id_rd` input 5: ID destination register.
- `id_writes` input 1: ID instruction writes `id_rd`.
- `id_is_halt` input 1: ID opcode is HALT.
- `ex_branch_taken` input 1: `IsBranchTaken` from EXE (registered, held while EXE is stalled).
- `mem_busy` input 1: data memory is not ready this cycle.
- `stall_if`, `stall_id` output 1 each: hold the stage register.
- `stall_exe` output 1: drives EXE `IsStall`.
- `stall_mem` output 1: hold the MEM stage.
- `flush_if`, `flush_id` output 1 each: replace the stage contents with NOP at the next edge.
- `bubble_exe` output 1: EXE receives NOP instead of the ID instruction.
- `halted` output 1: core stopped.
- `cnt_raw` output WIDTH: cycles lost to RAW stalls.
- `cnt_flush` output WIDTH: branch flushes taken.

## Operation
- FSM states: RUN, DRAIN, HALTED (2-bit encoding in the package).
- Scoreboard slots: `ex_slot` and `mem_slot`, each holding {valid, rd}.
- Hazard condition, `raw`: `id_valid` and some used source is nonzero and equals the rd of a valid slot. There is no forwarding. The register file is write-before-read, so the WB stage is never checked.
- Priority, highest first: `mem_busy`, branch flush, `raw`, halt.
- `mem_busy`:
  - Assert all four stalls.
  - No flush and no bubble.
  - Scoreboard, FSM and counters hold.
- Branch (`ex_branch_taken` and not `mem_busy`):
  - Assert `flush_if`, `flush_id` and `bubble_exe`.
  - Scoreboard: `mem_slot` takes `ex_slot`; `ex_slot` is cleared.
  - `cnt_flush` increments.
  - In DRAIN, the HALT was on the wrong path: the FSM returns to RUN.
- `raw` (no branch, no `mem_busy`):
  - Assert `stall_if`, `stall_id` and `bubble_exe`.
  - Scoreboard shifts with an empty `ex_slot`.
  - `cnt_raw` increments.
- Normal issue:
  - `ex_slot` takes {`id_valid` and `id_writes` and `id_rd` ≠ 0, `id_rd`}.
  - `mem_slot` takes `ex_slot`.
- HALT: when a HALT issues in RUN, the FSM enters DRAIN. The 2-bit drain counter loads 3.
- DRAIN:
  - `stall_if` and `stall_id` stay high; `bubble_exe` stays high.
  - The scoreboard shifts in empties.
  - The counter decrements on each cycle without `mem_busy`.
  - At 0 the FSM enters HALTED.
- HALTED:
  - All stalls high, `halted` = 1.
  - No flushes.
  - Only reset exits this state.
- Counters wrap modulo 2^WIDTH.

## Timing
- All stall, flush and bubble outputs are combinational from the current inputs plus registered state, valid in the same cycle. State updates at the next rising edge.
- RAW stall length:
  - Match on `ex_slot`: 2 cycles.
  - Match on `mem_slot` only: 1 cycle.
  - Each added cycle of `mem_busy` extends the stall by one cycle.
- Branch:
  - Flush lasts exactly one non-busy cycle per taken branch.
  - If `ex_branch_taken` coincides with `mem_busy`, the flush fires in the first cycle `mem_busy` is low.
- HALT to `halted`: 4 cycles after the issue edge (issue plus 3 drain cycles), extended by `mem_busy` cycles.
- Reset (asynchronous; applies mid-stall or mid-drain):
  - FSM → RUN; scoreboard slots invalid; drain counter 0; both counters 0.
  - All outputs 0 while `rst_n` is low and `mem_busy` is low.
  - `mem_busy` still forces the stalls during reset.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - FSM state encoding;
  - `DRAIN_CYCLES` = 3;
  - a slot struct or constant widths (`REG_W` = 5).
- One natural sub-module: `pipe_scoreboard`, containing the two slots, shift/hold/bubble control and the `raw` compare. The FSM, priority logic and counters stay in `pipe_ctrl`.

## Test plan
- Load-use: `lw r5` issues, next ID reads `rs`=5 → `stall_if`/`stall_id`/`bubble_exe` high for 2 cycles, `cnt_raw`=2. `rs`=0 with an `ex_slot` rd of 0 → no stall.
- Distance-2 dependency: the consumer appears one cycle later → 1 stall cycle. With `mem_busy` high for 3 cycles during that stall → stalls hold for 4 cycles and `cnt_raw` stays 1.
- Taken branch: pulse `ex_branch_taken` → `flush_if`/`flush_id`/`bubble_exe` for 1 cycle, `cnt_flush`=1. Raised together with `mem_busy` held for 2 cycles → flush appears on cycle 3 only.
- HALT: HALT in ID with no hazard → DRAIN, then `halted`=1 exactly 4 cycles later. After that, toggling `id_valid` and `ex_branch_taken` changes nothing.
- HALT squash: `ex_branch_taken` in the first DRAIN cycle → back to RUN with one flush and `halted` never set.
- Reset: drop `rst_n` mid-DRAIN with a RAW stall pending → all outputs 0 and counters 0 immediately. After release, normal issue resumes the next cycle with no stall.
